// File: rtl/ps2_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, 8 data + odd parity + stop, ack check.
// Latency: INHIBIT_CYCLES plus 11 device clocks; tx_start is ignored while busy and there is no backpressure on the device side.
module ps2_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clock50,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic       timeout_err
);

    localparam int MAX_CYCLES = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SHIFT, ACK, WAITREL} state_t;

    state_t          state, state_nxt;
    logic            clk_s1, clk_s2, clk_d;
    logic            dat_s1, dat_s2;
    logic            fe;
    logic [8:0]      shreg, shreg_nxt;
    logic [3:0]      bitcnt, bitcnt_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            tmo;
    logic            ack_ok, ack_ok_nxt;
    logic            done_nxt, ack_err_nxt, timeout_nxt;

    always_ff @(posedge clock50 or negedge reset_n) begin
        if (!reset_n) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            clk_d  <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk_i;
            clk_s2 <= clk_s1;
            clk_d  <= clk_s2;
            dat_s1 <= ps2_dat_i;
            dat_s2 <= dat_s1;
        end
    end

    assign fe  = clk_d & ~clk_s2;
    assign tmo = (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock50 or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            shreg       <= '0;
            bitcnt      <= '0;
            cnt         <= '0;
            ack_ok      <= 1'b0;
            done        <= 1'b0;
            ack_err     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            shreg       <= shreg_nxt;
            bitcnt      <= bitcnt_nxt;
            cnt         <= cnt_nxt;
            ack_ok      <= ack_ok_nxt;
            done        <= done_nxt;
            ack_err     <= ack_err_nxt;
            timeout_err <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bitcnt_nxt  = bitcnt;
        cnt_nxt     = cnt + CW'(1);
        ack_ok_nxt  = ack_ok;
        done_nxt    = 1'b0;
        ack_err_nxt = 1'b0;
        timeout_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (tx_start) begin
                    shreg_nxt  = {~^tx_data, tx_data};
                    bitcnt_nxt = '0;
                    ack_ok_nxt = 1'b0;
                    state_nxt  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt == CW'(INHIBIT_CYCLES - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (fe) begin
                    cnt_nxt    = '0;
                    bitcnt_nxt = '0;
                    state_nxt  = SHIFT;
                end else if (tmo) begin
                    state_nxt   = IDLE;
                    timeout_nxt = 1'b1;
                end
            end
            SHIFT: begin
                if (fe) begin
                    cnt_nxt = '0;
                    // bitcnt==8 means parity is on the line; this edge starts the stop bit
                    if (bitcnt == 4'd8) begin
                        state_nxt = ACK;
                    end else begin
                        shreg_nxt  = {1'b0, shreg[8:1]};
                        bitcnt_nxt = bitcnt + 4'd1;
                    end
                end else if (tmo) begin
                    state_nxt   = IDLE;
                    timeout_nxt = 1'b1;
                end
            end
            ACK: begin
                if (fe) begin
                    cnt_nxt     = '0;
                    state_nxt   = WAITREL;
                    ack_ok_nxt  = ~dat_s2;
                    ack_err_nxt = dat_s2;
                end else if (tmo) begin
                    state_nxt   = IDLE;
                    timeout_nxt = 1'b1;
                end
            end
            WAITREL: begin
                if (clk_s2 && dat_s2) begin
                    state_nxt = IDLE;
                    done_nxt  = ack_ok;
                end else if (fe) begin
                    cnt_nxt = '0;
                end else if (tmo) begin
                    // a failed ack already reported; keep a single error pulse per transfer
                    state_nxt   = IDLE;
                    timeout_nxt = ack_ok;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ps2_clk_oe = (state == INHIBIT);
        ps2_dat_oe = (state == REQ) || ((state == SHIFT) && !shreg[0]);
        busy       = (state != IDLE);
    end

endmodule

// File: tb/tb_ps2_tx.sv
// Randomized scoreboard bench for ps2_tx with a behavioural PS/2 keyboard model on the open-drain lines.
module tb_ps2_tx;

    localparam int INH = 10;
    localparam int TMO = 100;
    localparam int H   = 10;

    logic       clock50 = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       ps2_clk_i, ps2_dat_i;
    logic       ps2_clk_oe, ps2_dat_oe, busy, done, ack_err, timeout_err;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;

    typedef struct {
        logic [9:0] bits;
        int         code;
    } exp_t;

    exp_t       exp_q[$];
    logic [9:0] dev_q[$];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         last_fall = 0;
    bit         fin = 1'b0;

    assign ps2_clk_i = dev_clk & ~ps2_clk_oe;
    assign ps2_dat_i = dev_dat & ~ps2_dat_oe;

    ps2_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clock50    (clock50),
        .reset_n    (reset_n),
        .tx_data    (tx_data),
        .tx_start   (tx_start),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_dat_i  (ps2_dat_i),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_dat_oe (ps2_dat_oe),
        .busy       (busy),
        .done       (done),
        .ack_err    (ack_err),
        .timeout_err(timeout_err)
    );

    always #5 clock50 = ~clock50;
    always @(posedge clock50) cyc <= cyc + 1;

    // Line order as the keyboard sees it: data LSB first, odd parity, stop bit high.
    function automatic logic [9:0] frame_bits(input logic [7:0] d);
        logic p;
        p = ($countones(d) % 2 == 0);
        return {1'b1, p, d};
    endfunction

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // Keyboard: waits for request-to-send, clocks np pulses, samples bits 1..10, optionally acks on pulse 11.
    task automatic device(input int np, input bit do_ack, input int rst_at);
        int         w;
        logic [9:0] cap;
        w   = 0;
        cap = '0;
        while (!(ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1) && w < 5000) begin
            @(negedge clock50);
            w++;
        end
        total++;
        if (w >= 5000) begin
            bad++;
            $display("FAIL req_wait got=timeout want=request");
            return;
        end
        repeat (5) @(negedge clock50);
        for (int p = 1; p <= np; p++) begin
            if (p == 11 && do_ack) begin
                dev_dat = 1'b0;
                repeat (5) @(negedge clock50);
            end
            dev_clk   = 1'b0;
            last_fall = cyc;
            if (p == rst_at) begin
                repeat (6) @(negedge clock50);
                return;
            end
            repeat (H - 1) @(negedge clock50);
            if (p <= 10) cap[p-1] = ps2_dat_i;
            @(negedge clock50);
            dev_clk = 1'b1;
            if (p == 10) dev_q.push_back(cap);
            repeat (H) @(negedge clock50);
            dev_dat = 1'b1;
        end
    endtask

    task automatic send(input logic [7:0] d, input int np, input bit do_ack, input int rst_at,
                        input int code, input bit extra);
        exp_t e;
        int   w;
        if (rst_at == 0) begin
            e.bits = frame_bits(d);
            e.code = code;
            exp_q.push_back(e);
        end
        @(negedge clock50);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clock50);
        tx_start = 1'b0;
        tx_data  = 8'($urandom);
        chk("busy_after_start", busy, 1);
        if (extra) begin
            repeat (3) @(negedge clock50);
            tx_data  = 8'h55;
            tx_start = 1'b1;
            @(negedge clock50);
            tx_start = 1'b0;
        end
        device(np, do_ack, rst_at);
        if (rst_at != 0) begin
            chk("busy_before_reset", busy, 1);
            #2 reset_n = 1'b0;
            #1;
            chk("rst_clk_oe", ps2_clk_oe, 0);
            chk("rst_dat_oe", ps2_dat_oe, 0);
            chk("rst_busy", busy, 0);
            dev_clk = 1'b1;
            dev_dat = 1'b1;
            repeat (3) @(negedge clock50);
            reset_n = 1'b1;
            repeat (60) @(negedge clock50);
            chk("idle_after_reset", busy, 0);
            return;
        end
        w = 0;
        while (busy && w < 1000) begin
            @(negedge clock50);
            w++;
        end
        total++;
        if (w >= 1000) begin
            bad++;
            $display("FAIL busy_release got=busy want=idle");
        end
        dev_clk = 1'b1;
        dev_dat = 1'b1;
        repeat (5) @(negedge clock50);
        chk("stays_idle", busy, 0);
    endtask

    initial begin
        fork
            begin : stim
                logic [7:0] d;
                bit         a;
                repeat (3) @(negedge clock50);
                chk("reset_clk_oe", ps2_clk_oe, 0);
                chk("reset_dat_oe", ps2_dat_oe, 0);
                chk("reset_busy", busy, 0);
                chk("reset_done", done, 0);
                chk("reset_ack_err", ack_err, 0);
                chk("reset_timeout", timeout_err, 0);
                reset_n = 1'b1;
                repeat (3) @(negedge clock50);
                send(8'hED, 11, 1'b1, 0, 0, 1'b0);
                send(8'h00, 11, 1'b1, 0, 0, 1'b0);
                send(8'h01, 11, 1'b1, 0, 0, 1'b0);
                for (int i = 0; i < 8; i++) begin
                    d = 8'($urandom);
                    a = ($urandom_range(0, 3) != 0);
                    send(d, 11, a, 0, a ? 0 : 1, 1'b0);
                end
                send(8'hAA, 11, 1'b0, 0, 1, 1'b0);
                send(8'h3C, 4, 1'b1, 0, 2, 1'b0);
                send(8'hF4, 11, 1'b1, 0, 0, 1'b1);
                send(8'h99, 11, 1'b1, 5, 0, 1'b0);
                send(8'($urandom), 11, 1'b1, 0, 0, 1'b0);
                repeat (20) @(negedge clock50);
                fin = 1'b1;
            end
            begin : mon
                exp_t       e;
                logic [9:0] f;
                int         got, el;
                while (!fin) begin
                    @(negedge clock50);
                    if (reset_n && (done || ack_err || timeout_err)) begin
                        chk("single_pulse", int'(done) + int'(ack_err) + int'(timeout_err), 1);
                        got = done ? 0 : (ack_err ? 1 : 2);
                        total++;
                        if (exp_q.size() == 0) begin
                            bad++;
                            $display("FAIL unexpected_pulse got=code%0d want=none", got);
                        end else begin
                            e = exp_q.pop_front();
                            if (got != e.code) begin
                                bad++;
                                $display("FAIL outcome got=code%0d want=code%0d", got, e.code);
                            end
                            if (e.code != 2 && got != 2) begin
                                if (dev_q.size() == 0) begin
                                    chk("frame_present", 0, 1);
                                end else begin
                                    f = dev_q.pop_front();
                                    chk("frame_bits", int'(f), int'(e.bits));
                                end
                            end
                            if (got == 0) chk("busy_at_done", busy, 0);
                            if (got == 2) begin
                                el = cyc - last_fall;
                                total++;
                                if (el < TMO || el > TMO + 6) begin
                                    bad++;
                                    $display("FAIL timeout_latency got=%0d want=%0d..%0d", el, TMO, TMO + 6);
                                end
                                chk("timeout_clk_rel", ps2_clk_oe, 0);
                                chk("timeout_dat_rel", ps2_dat_oe, 0);
                            end
                        end
                    end
                end
            end
            begin : inh
                int run;
                run = 0;
                while (!fin) begin
                    @(negedge clock50);
                    if (ps2_clk_oe) begin
                        run++;
                    end else if (run != 0) begin
                        chk("inhibit_len", run, INH);
                        run = 0;
                    end
                end
            end
            begin : wdog
                while (!fin && cyc < 90000) @(negedge clock50);
                if (!fin) begin
                    bad++;
                    $display("FAIL watchdog got=%0d cycles want=finish", cyc);
                    $display("test done: total=%0d bad=%0d", total, bad);
                    $fatal(1, "watchdog expired");
                end
            end
        join
        chk("exp_q_empty", exp_q.size(), 0);
        chk("dev_q_empty", dev_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_tx.md
PS2_TX -- requirements
Module: ps2_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 5000, number of clock50 cycles the host holds PS/2 clock low before a request (100 us at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 750000, maximum clock50 cycles allowed between successive device clock falling edges once the request is issued (15 ms).
REQ-003 SHALL have port clock50, input, 1 bit, the single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port tx_data, input, 8 bits, command byte to send to the keyboard.
REQ-006 SHALL have port tx_start, input, 1 bit, one-cycle request to send tx_data.
REQ-007 SHALL have port ps2_clk_i, input, 1 bit, raw PS/2 clock line level (asynchronous).
REQ-008 SHALL have port ps2_dat_i, input, 1 bit, raw PS/2 data line level (asynchronous).
REQ-009 SHALL have port ps2_clk_oe, output, 1 bit; 1 = pull PS/2 clock low, 0 = release (open drain).
REQ-010 SHALL have port ps2_dat_oe, output, 1 bit; 1 = pull PS/2 data low, 0 = release.
REQ-011 SHALL have port busy, output, 1 bit, high from acceptance of tx_start until return to IDLE.
REQ-012 SHALL have port done, output, 1 bit, one-cycle pulse on successful acknowledged transfer.
REQ-013 SHALL have port ack_err, output, 1 bit, one-cycle pulse when the device does not acknowledge.
REQ-014 SHALL have port timeout_err, output, 1 bit, one-cycle pulse on transfer timeout.

Function
REQ-015 SHALL pass ps2_clk_i and ps2_dat_i each through a 2-flop synchronizer; a falling edge (fe) is synchronized clock 1 in previous cycle, 0 in current.
REQ-016 SHALL use states IDLE, INHIBIT, REQ, SHIFT, ACK, WAITREL.
REQ-017 IDLE: outputs released, busy=0; tx_start=1 latches {odd parity, tx_data} into a 9-bit shift register, clears bit counter and cycle counter, enters INHIBIT next cycle with busy=1.
REQ-018 Odd parity bit SHALL equal NOT(XOR of tx_data[7:0]).
REQ-019 tx_start while busy=1 SHALL be ignored; tx_data is sampled only on the accepted cycle.
REQ-020 INHIBIT: ps2_clk_oe=1, ps2_dat_oe=0 for exactly INHIBIT_CYCLES cycles, then REQ.
REQ-021 REQ: ps2_dat_oe=1 (start bit 0), ps2_clk_oe=0; on first fe enter SHIFT and drive bit 0.
REQ-022 SHIFT: on each fe advance one bit, LSB first; ps2_dat_oe = NOT(current bit); after parity has been driven, the next fe releases data (stop bit 1) and enters ACK.
REQ-023 Sequence per frame: fe #1..#8 present data bits 0..7, fe #9 parity, fe #10 stop (released), fe #11 samples ack.
REQ-024 ACK: on fe, synchronized data 0 = ack good, 1 = ack_err pulse; either way enter WAITREL.
REQ-025 WAITREL: wait until synchronized clock and data both 1, then pulse done (if ack good) and return to IDLE, busy=0 same cycle as done.
REQ-026 Cycle counter SHALL reset on every fe and on state entry; in REQ, SHIFT, ACK, WAITREL reaching TIMEOUT_CYCLES pulses timeout_err, releases both lines, returns to IDLE.
REQ-027 ack_err and timeout_err SHALL NOT pulse done; at most one of done/ack_err/timeout_err pulses per transfer, except ack_err followed by done is forbidden.
REQ-028 Counters SHALL be wide enough for max(INHIBIT_CYCLES, TIMEOUT_CYCLES) without wrap.

Reset
REQ-029 reset_n=0 SHALL immediately force IDLE, ps2_clk_oe=0, ps2_dat_oe=0, busy=0, done=0, ack_err=0, timeout_err=0, shift register and counters 0, synchronizers to 1.
REQ-030 reset_n asserted mid-transfer SHALL release both lines immediately with no error pulse; after release, only a new tx_start starts a transfer.

Verification
REQ-031 INHIBIT_CYCLES=10, send 0xED, device model clocks and acks -> clk_oe high 10 cycles, data bits 1,0,1,1,0,1,1,1, parity 1, one done pulse, busy low after.
REQ-032 Send 0x00 then 0x01 -> parity 1 then 0, both done.
REQ-033 Device holds data high on 11th fe -> ack_err pulse once, no done, IDLE after lines high.
REQ-034 TIMEOUT_CYCLES=100, device stops clocking after fe #4 -> timeout_err at 100 cycles after last fe, lines released.
REQ-035 tx_start=1 with 0x55 while busy sending 0xF4 -> only 0xF4 frame appears, one done.
REQ-036 reset_n low during SHIFT -> ps2_clk_oe=ps2_dat_oe=0 same cycle, busy=0, no pulses.
